// File: rtl/divisor_secuencial.sv
// divisor_secuencial: unsigned restoring divider, one trial subtraction per
// clock, built on an ANCHO+1-bit ripple-borrow subtractor.
// Optional build macro: DIVISOR_DETECCION_CERO_EN -- when defined, a zero
// divisor skips the iterations, goes straight to FIN and raises error_div.
// Without it, error_div is tied low and Y=0 runs the normal algorithm.
module divisor_secuencial #(
  parameter int unsigned ANCHO = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inicio,
  input  logic [ANCHO-1:0] X,
  input  logic [ANCHO-1:0] Y,
  output logic             ocupado,
  output logic             listo,
  output logic [ANCHO-1:0] cociente,
  output logic [ANCHO-1:0] residuo,
  output logic             error_div
);

  localparam int unsigned    CW     = $clog2(ANCHO + 1);
  localparam logic [CW-1:0]  ULTIMA = CW'(ANCHO - 1);

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    CALCULO = 2'd1,
    FIN     = 2'd2
  } estado_t;

  estado_t          estado_q, estado_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ANCHO-1:0] div_q, div_d;   // captured divisor
  logic [ANCHO-1:0] rem_q, rem_d;   // partial remainder
  logic [ANCHO-1:0] quo_q, quo_d;   // dividend shifting out / quotient shifting in
  logic [ANCHO-1:0] coc_q, coc_d;
  logic [ANCHO-1:0] res_q, res_d;
  logic             listo_q, listo_d;
`ifdef DIVISOR_DETECCION_CERO_EN
  logic             err_q, err_d;
`endif

  // Trial subtraction datapath
  logic [ANCHO:0]   minuendo;
  logic [ANCHO-1:0] resta;
  logic             prestamo;
  logic             borrow;

  // Ripple-borrow subtractor: {rem, next dividend bit} - {0, divisor}.
  // The top difference bit is never kept (a non-borrowing result always
  // fits ANCHO bits), so the last stage only produces the borrow out.
  always_comb begin
    minuendo = {rem_q, quo_q[ANCHO-1]};
    resta    = '0;
    borrow   = 1'b0;
    for (int unsigned i = 0; i < ANCHO; i++) begin
      resta[i] = minuendo[i] ^ div_q[i] ^ borrow;
      borrow   = (~minuendo[i] & div_q[i]) | (~(minuendo[i] ^ div_q[i]) & borrow);
    end
    prestamo = ~minuendo[ANCHO] & borrow;
  end

  // Next-state and datapath update logic
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    coc_d    = coc_q;
    res_d    = res_q;
    listo_d  = 1'b0;
`ifdef DIVISOR_DETECCION_CERO_EN
    err_d    = err_q;
`endif
    case (estado_q)
      REPOSO: begin
        if (inicio) begin
          div_d    = Y;
          quo_d    = X;
          rem_d    = '0;
          cnt_d    = '0;
          estado_d = CALCULO;
`ifdef DIVISOR_DETECCION_CERO_EN
          err_d    = 1'b0;
          if (Y == '0) begin
            estado_d = FIN;
            coc_d    = '1;
            res_d    = X;
            err_d    = 1'b1;
          end
`endif
        end
      end
      CALCULO: begin
        quo_d = {quo_q[ANCHO-2:0], ~prestamo};
        rem_d = prestamo ? minuendo[ANCHO-1:0] : resta;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ULTIMA) begin
          estado_d = FIN;
          cnt_d    = '0;
          coc_d    = {quo_q[ANCHO-2:0], ~prestamo};
          res_d    = prestamo ? minuendo[ANCHO-1:0] : resta;
        end
      end
      FIN: begin
        estado_d = REPOSO;
        listo_d  = 1'b1;
      end
      default: begin
        estado_d = REPOSO;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= REPOSO;
      cnt_q    <= '0;
      div_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      coc_q    <= '0;
      res_q    <= '0;
      listo_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      coc_q    <= coc_d;
      res_q    <= res_d;
      listo_q  <= listo_d;
    end
  end

`ifdef DIVISOR_DETECCION_CERO_EN
  // Divide-by-zero flag, held until the next capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign error_div = err_q;
`else
  assign error_div = 1'b0;
`endif

  assign ocupado  = (estado_q == CALCULO);
  assign listo    = listo_q;
  assign cociente = coc_q;
  assign residuo  = res_q;

endmodule

// File: tb/tb_divisor_secuencial.sv
// Bench for divisor_secuencial: scoreboard of expected results pushed when a
// division is started and popped whenever the DUT raises listo.
module tb_divisor_secuencial;

  localparam int unsigned ANCHO = 4;
`ifdef DIVISOR_DETECCION_CERO_EN
  localparam int DET = 1;
`else
  localparam int DET = 0;
`endif

  logic             clk;
  logic             rst_n;
  logic             inicio;
  logic [ANCHO-1:0] X;
  logic [ANCHO-1:0] Y;
  logic             ocupado;
  logic             listo;
  logic [ANCHO-1:0] cociente;
  logic [ANCHO-1:0] residuo;
  logic             error_div;

  typedef struct {
    int coc;
    int res;
    int err;
  } esperado_t;

  esperado_t sb[$];
  esperado_t e_mon;
  int n_chk = 0;
  int n_ok  = 0;

  divisor_secuencial #(.ANCHO(ANCHO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inicio    (inicio),
    .X         (X),
    .Y         (Y),
    .ocupado   (ocupado),
    .listo     (listo),
    .cociente  (cociente),
    .residuo   (residuo),
    .error_div (error_div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic comprobar(input string tag, input int obs, input int esp);
    n_chk++;
    if (obs == esp) n_ok++;
    else $display("FAIL %s: obtenido=%0d esperado=%0d", tag, obs, esp);
  endtask

  function automatic esperado_t modelo(input int x, input int y);
    esperado_t e;
    if (y == 0) begin
      e.coc = (1 << ANCHO) - 1;
      e.res = x;
      e.err = DET;
    end else begin
      e.coc = x / y;
      e.res = x % y;
      e.err = 0;
    end
    return e;
  endfunction

  // Scoreboard consumer: every listo pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && listo) begin
      if (sb.size() == 0) begin
        comprobar("listo_sin_transaccion", 1, 0);
      end else begin
        e_mon = sb.pop_front();
        comprobar("cociente", int'(cociente), e_mon.coc);
        comprobar("residuo", int'(residuo), e_mon.res);
        comprobar("error_div", int'(error_div), e_mon.err);
      end
    end
  end

  // Called at a negedge. Starts one division, scrambles X/Y after capture,
  // optionally pulses inicio mid-calculation, checks latency and hold.
  task automatic dividir(input int x, input int y, input bit pulsar);
    esperado_t e;
    int lat    = -1;
    int n_ocup = 0;
    int n_lis  = 0;
    int lat_esp;
    int ocup_esp;
    logic [31:0] vx;
    logic [31:0] vy;
    e  = modelo(x, y);
    vx = x;
    vy = y;
    lat_esp  = (y == 0 && DET == 1) ? 1 : ANCHO + 1;
    ocup_esp = (y == 0 && DET == 1) ? 0 : ANCHO;
    X = vx[ANCHO-1:0];
    Y = vy[ANCHO-1:0];
    inicio = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    inicio = 1'b0;
    X = ANCHO'($urandom);
    Y = ANCHO'($urandom);
    for (int j = 0; j < ANCHO + 8; j++) begin
      if (j > 0) @(negedge clk);
      if (ocupado) n_ocup++;
      if (listo) begin
        n_lis++;
        if (lat < 0) lat = j;
      end
      if (pulsar && j == 1) begin
        inicio = 1'b1;
        X = 2;
        Y = 1;
      end
      if (pulsar && j == 2) inicio = 1'b0;
    end
    comprobar("latencia_listo", lat, lat_esp);
    comprobar("ciclos_ocupado", n_ocup, ocup_esp);
    comprobar("pulsos_listo", n_lis, 1);
    comprobar("cociente_retenido", int'(cociente), e.coc);
    comprobar("residuo_retenido", int'(residuo), e.res);
    comprobar("error_retenido", int'(error_div), e.err);
  endtask

  // inicio held high: back-to-back divisions every ANCHO+2 cycles
  task automatic continuo();
    int p1 = -1;
    int p2 = -1;
    X = 13;
    Y = 4;
    sb.push_back(modelo(13, 4));
    sb.push_back(modelo(13, 4));
    inicio = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (listo) begin
        if (p1 < 0) p1 = j;
        else begin
          p2 = j;
          break;
        end
      end
    end
    inicio = 1'b0;
    comprobar("periodo_continuo", p2 - p1, ANCHO + 2);
    repeat (ANCHO + 4) @(negedge clk);
  endtask

  // Reset during the second CALCULO cycle, then a division right after release
  task automatic reset_en_calculo();
    int n_lis = 0;
    X = 13;
    Y = 4;
    inicio = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inicio = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    comprobar("rst_ocupado", int'(ocupado), 0);
    comprobar("rst_listo", int'(listo), 0);
    comprobar("rst_cociente", int'(cociente), 0);
    comprobar("rst_residuo", int'(residuo), 0);
    comprobar("rst_error", int'(error_div), 0);
    repeat (3) begin
      @(negedge clk);
      if (listo) n_lis++;
    end
    comprobar("rst_sin_listo", n_lis, 0);
    rst_n = 1'b1;
    dividir(12, 5, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: obtenido=timeout esperado=fin");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n  = 1'b0;
    inicio = 1'b0;
    X      = '0;
    Y      = '0;
    repeat (2) @(negedge clk);
    comprobar("reset_ocupado", int'(ocupado), 0);
    comprobar("reset_listo", int'(listo), 0);
    comprobar("reset_cociente", int'(cociente), 0);
    comprobar("reset_residuo", int'(residuo), 0);
    comprobar("reset_error", int'(error_div), 0);
    rst_n = 1'b1;
    @(negedge clk);

    dividir(13, 4, 1'b0);
    dividir(15, 1, 1'b0);
    dividir(3, 7, 1'b0);
    dividir(0, 5, 1'b0);
    dividir(9, 0, 1'b0);
    dividir(15, 15, 1'b0);
    dividir(13, 4, 1'b1);
    continuo();
    reset_en_calculo();
    for (int i = 0; i < 6; i++) begin
      dividir(int'($urandom_range(0, 15)), int'($urandom_range(1, 15)), 1'b0);
    end

    repeat (4) @(negedge clk);
    comprobar("scoreboard_vacio", sb.size(), 0);
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
